// File: rtl/resizer_pkg.sv
// Shared lane layout and sizing helpers for the stream resizer.
package resizer_pkg;

   localparam int unsigned DFLT_DATA_W = 1;
   localparam int unsigned LANE_W      = 2 + DFLT_DATA_W;

   localparam int unsigned KEEP_BIT = 0;
   localparam int unsigned LAST_BIT = 1;
   localparam int unsigned DATA_LSB = 2;

   typedef struct packed {
      logic [DFLT_DATA_W-1:0] data;
      logic                   last;
      logic                   keep;
   } lane_t;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// Circular lane buffer: up to S_LANES written and M_LANES read per cycle.
module lane_fifo
   import resizer_pkg::*;
#(
   parameter int unsigned LANE_BITS = 3,
   parameter int unsigned S_LANES   = 3,
   parameter int unsigned M_LANES   = 2,
   parameter int unsigned DEPTH     = 8,
   localparam int unsigned CW = cnt_width(DEPTH),
   localparam int unsigned PW = ptr_width(DEPTH),
   localparam int unsigned SW = cnt_width(S_LANES),
   localparam int unsigned MW = cnt_width(M_LANES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [S_LANES-1:0][LANE_BITS-1:0] wr_lanes,
   input  logic [SW-1:0]                     wr_num,
   input  logic [MW-1:0]                     rd_num,
   output logic [M_LANES-1:0][LANE_BITS-1:0] rd_lanes,
   output logic [CW-1:0]                     count
);

   logic [LANE_BITS-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_q, rd_q;
   logic [CW-1:0]        count_q;

   // Lanes are stored unreset; only slots below count are ever exposed.
   always_ff @(posedge clk) begin
      for (int k = 0; k < S_LANES; k++) begin
         if (SW'(k) < wr_num) begin
            mem[wr_q + PW'(k)] <= wr_lanes[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_q + PW'(wr_num);
         rd_q    <= rd_q + PW'(rd_num);
         count_q <= count_q + CW'(wr_num) - CW'(rd_num);
      end
   end

   always_comb begin
      for (int j = 0; j < M_LANES; j++) begin
         rd_lanes[j] = mem[rd_q + PW'(j)];
      end
   end

   assign count = count_q;

endmodule

// File: rtl/slave_packer.sv
// Compacts kept input lanes into the lane FIFO and presents packet-bounded
// output entries to the output stage.
module slave_packer
   import resizer_pkg::*;
#(
   parameter int unsigned S_KEEP_WIDTH     = 3,
   parameter int unsigned T_DATA_WIDTH     = 1,
   parameter int unsigned M_KEEP_WIDTH     = 2,
   parameter int unsigned DEPTH            = 8,
   parameter int unsigned BUF_OUT_ENTRY_SZ = (2 + T_DATA_WIDTH) * M_KEEP_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid_i,
   output logic                        s_ready_o,
   input  logic                        s_last_i,
   input  logic [S_KEEP_WIDTH-1:0]     s_keep_i,
   input  logic [T_DATA_WIDTH-1:0]     s_data_i [S_KEEP_WIDTH],
   output logic                        underflow,
   input  logic                        master_entry_ready,
   output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry
);

   localparam int unsigned LW = 2 + T_DATA_WIDTH;
   localparam int unsigned CW = cnt_width(DEPTH);
   localparam int unsigned SW = cnt_width(S_KEEP_WIDTH);
   localparam int unsigned MW = cnt_width(M_KEEP_WIDTH);

   logic [S_KEEP_WIDTH-1:0][LW-1:0] wr_lanes;
   logic [M_KEEP_WIDTH-1:0][LW-1:0] rd_lanes;
   logic [SW-1:0]                   kept_num, wr_num;
   logic [MW-1:0]                   valid_num, rd_num;
   logic [CW-1:0]                   count;
   logic [CW-1:0]                   last_cnt_q, last_cnt_d;
   logic                            push, pop, push_last, pop_last;

   // Squeeze out null lanes; the tail of the packet is the highest kept lane.
   always_comb begin
      wr_lanes = '0;
      kept_num = '0;
      for (int i = 0; i < S_KEEP_WIDTH; i++) begin
         if (s_keep_i[i]) begin
            wr_lanes[kept_num][KEEP_BIT]                  = 1'b1;
            wr_lanes[kept_num][DATA_LSB +: T_DATA_WIDTH] = s_data_i[i];
            kept_num = kept_num + SW'(1);
         end
      end
      if (kept_num != '0) begin
         wr_lanes[kept_num - SW'(1)][LAST_BIT] = s_last_i;
      end
   end

   assign s_ready_o = !rst && ((CW'(DEPTH) - count) >= CW'(S_KEEP_WIDTH));
   assign push      = s_valid_i && s_ready_o;
   assign wr_num    = push ? kept_num : '0;
   assign push_last = push && s_last_i && (kept_num != '0);

   // An entry stops after the first last-tagged lane so it never spans packets.
   always_comb begin
      master_entry = '0;
      valid_num    = '0;
      pop_last     = 1'b0;
      for (int j = 0; j < M_KEEP_WIDTH; j++) begin
         if ((CW'(j) < count) && !pop_last) begin
            master_entry[j*LW +: LW] = rd_lanes[j];
            valid_num = valid_num + MW'(1);
            pop_last  = rd_lanes[j][LAST_BIT];
         end
      end
   end

   assign underflow  = (count < CW'(M_KEEP_WIDTH)) && (last_cnt_q == '0);
   assign pop        = master_entry_ready && !underflow;
   assign rd_num     = pop ? valid_num : '0;
   assign last_cnt_d = last_cnt_q + CW'(push_last) - CW'(pop && pop_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_cnt_q <= '0;
      end else begin
         last_cnt_q <= last_cnt_d;
      end
   end

   lane_fifo #(
      .LANE_BITS (LW),
      .S_LANES   (S_KEEP_WIDTH),
      .M_LANES   (M_KEEP_WIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_lanes (wr_lanes),
      .wr_num   (wr_num),
      .rd_num   (rd_num),
      .rd_lanes (rd_lanes),
      .count    (count)
   );

   // A last-tagged beat with no kept lanes has nowhere to carry its tag.
   a_no_empty_last: assert property (@(posedge clk) disable iff (rst)
      !(push && s_last_i && (s_keep_i == '0)));

endmodule

// File: tb/tb_slave_packer.sv
// Directed bench for slave_packer at S=3, M=2, W=1, DEPTH=8.
module tb_slave_packer;

   localparam int unsigned S = 3;
   localparam int unsigned M = 2;
   localparam int unsigned W = 1;
   localparam int unsigned D = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid_i, s_ready_o, s_last_i;
   logic [S-1:0]     s_keep_i;
   logic [W-1:0]     s_data_i [S];
   logic             underflow, master_entry_ready;
   logic [3*M-1:0]   master_entry;

   int nvec = 0;
   int nerr = 0;

   slave_packer #(
      .S_KEEP_WIDTH (S),
      .T_DATA_WIDTH (W),
      .M_KEEP_WIDTH (M),
      .DEPTH        (D)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .s_valid_i          (s_valid_i),
      .s_ready_o          (s_ready_o),
      .s_last_i           (s_last_i),
      .s_keep_i           (s_keep_i),
      .s_data_i           (s_data_i),
      .underflow          (underflow),
      .master_entry_ready (master_entry_ready),
      .master_entry       (master_entry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [2:0] keep, input logic [2:0] data, input logic last);
      s_valid_i = 1'b1;
      s_keep_i  = keep;
      s_last_i  = last;
      for (int i = 0; i < S; i++) s_data_i[i] = data[i];
   endtask

   task automatic idle();
      s_valid_i = 1'b0;
      s_keep_i  = '0;
      s_last_i  = 1'b0;
      for (int i = 0; i < S; i++) s_data_i[i] = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic pop_once();
      master_entry_ready = 1'b1;
      step();
      master_entry_ready = 1'b0;
      settle();
   endtask

   function automatic bit lane_bit(input int x);
      return bit'(x[0] ^ x[2]);
   endfunction

   initial begin
      bit           q[$];
      int           b, cyc;
      logic [2:0]   d;
      bit           exp_ready, exp_uf;

      idle();
      master_entry_ready = 1'b0;
      rst = 1'b1;
      settle();
      check("rst_underflow", 32'(underflow), 32'd1);
      check("rst_entry", 32'(master_entry), 32'd0);
      step();
      rst = 1'b0;
      settle();
      check("rst_ready", 32'(s_ready_o), 32'd1);
      check("rst_count", 32'(dut.count), 32'd0);

      // Single full beat, tail flushes a partial entry
      beat(3'b111, 3'b101, 1'b1);
      settle();
      check("t1_ready", 32'(s_ready_o), 32'd1);
      step();
      idle();
      settle();
      check("t1_count", 32'(dut.count), 32'd3);
      check("t1_entry1", 32'(master_entry), 32'b001101);
      check("t1_uf1", 32'(underflow), 32'd0);
      pop_once();
      check("t1_entry2", 32'(master_entry), 32'b000111);
      check("t1_uf2", 32'(underflow), 32'd0);
      pop_once();
      check("t1_entry3", 32'(master_entry), 32'd0);
      check("t1_uf3", 32'(underflow), 32'd1);
      check("t1_count3", 32'(dut.count), 32'd0);

      // Zero-keep beat dropped; holes squeezed out
      beat(3'b000, 3'b000, 1'b0);
      step();
      idle();
      settle();
      check("t2_zero_keep", 32'(dut.count), 32'd0);
      beat(3'b101, 3'b001, 1'b0);
      step();
      idle();
      settle();
      check("t2_count", 32'(dut.count), 32'd2);
      check("t2_entry", 32'(master_entry), 32'b001101);
      check("t2_uf", 32'(underflow), 32'd0);
      pop_once();
      check("t2_drain", 32'(dut.count), 32'd0);

      // Two packets: entries must not straddle the boundary
      beat(3'b001, 3'b001, 1'b1);
      step();
      beat(3'b111, 3'b110, 1'b1);
      step();
      idle();
      settle();
      check("t3_count", 32'(dut.count), 32'd4);
      check("t3_entry1", 32'(master_entry), 32'b000111);
      pop_once();
      check("t3_count2", 32'(dut.count), 32'd3);
      check("t3_entry2", 32'(master_entry), 32'b101001);
      pop_once();
      check("t3_entry3", 32'(master_entry), 32'b000111);
      pop_once();
      check("t3_uf", 32'(underflow), 32'd1);
      check("t3_empty", 32'(master_entry), 32'd0);

      // Steady push and pop across pointer wrap
      master_entry_ready = 1'b1;
      b = 0;
      cyc = 0;
      while (b < 20 && cyc < 200) begin
         for (int i = 0; i < S; i++) d[i] = lane_bit(b * S + i);
         beat(3'b111, d, 1'b0);
         settle();
         exp_ready = (D - q.size()) >= S;
         exp_uf    = q.size() < M;
         check("t5_ready", 32'(s_ready_o), 32'(exp_ready));
         check("t5_uf", 32'(underflow), 32'(exp_uf));
         check("t5_count", 32'(dut.count), 32'(q.size()));
         if (!exp_uf) begin
            check("t5_entry", 32'(master_entry), 32'({q[1], 2'b01, q[0], 2'b01}));
         end
         step();
         if (!exp_uf) begin
            void'(q.pop_front());
            void'(q.pop_front());
         end
         if (exp_ready) begin
            for (int i = 0; i < S; i++) q.push_back(d[i]);
            b++;
         end
         cyc++;
      end
      check("t5_beats_done", 32'(b), 32'd20);
      idle();
      master_entry_ready = 1'b0;
      rst = 1'b1;
      settle();
      check("t5_rst_uf", 32'(underflow), 32'd1);
      step();
      rst = 1'b0;
      settle();

      // Backpressure: full holds the beat until a pop frees space
      beat(3'b111, 3'b111, 1'b0);
      settle();
      check("t4_ready0", 32'(s_ready_o), 32'd1);
      step();
      check("t4_count1", 32'(dut.count), 32'd3);
      check("t4_ready1", 32'(s_ready_o), 32'd1);
      step();
      check("t4_count2", 32'(dut.count), 32'd6);
      check("t4_full", 32'(s_ready_o), 32'd0);
      step();
      check("t4_held", 32'(dut.count), 32'd6);
      master_entry_ready = 1'b1;
      settle();
      check("t4_ready_prepop", 32'(s_ready_o), 32'd0);
      step();
      master_entry_ready = 1'b0;
      settle();
      check("t4_count_pop", 32'(dut.count), 32'd4);
      check("t4_ready_rise", 32'(s_ready_o), 32'd1);
      step();
      idle();
      settle();
      check("t4_count7", 32'(dut.count), 32'd7);
      check("t4_ready7", 32'(s_ready_o), 32'd0);
      pop_once();
      check("t4_count5", 32'(dut.count), 32'd5);
      check("t4_uf5", 32'(underflow), 32'd0);

      // Reset mid-packet discards everything
      rst = 1'b1;
      settle();
      check("t6_rst_uf", 32'(underflow), 32'd1);
      check("t6_rst_entry", 32'(master_entry), 32'd0);
      check("t6_rst_count", 32'(dut.count), 32'd0);
      step();
      rst = 1'b0;
      settle();
      check("t6_ready", 32'(s_ready_o), 32'd1);
      beat(3'b011, 3'b001, 1'b1);
      step();
      idle();
      settle();
      check("t6_count", 32'(dut.count), 32'd2);
      check("t6_entry", 32'(master_entry), 32'b011101);
      check("t6_uf", 32'(underflow), 32'd0);
      pop_once();
      check("t6_uf_end", 32'(underflow), 32'd1);
      check("t6_entry_end", 32'(master_entry), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/slave_packer.md
Name: slave_packer

Overview:
- Receive side of the resizer: accepts S_KEEP_WIDTH-lane AXI-Stream beats and compacts the kept lanes into a lane FIFO.
- Presents M_KEEP_WIDTH-lane entries on the master_entry/master_entry_ready/underflow interface consumed by the output stage.
- Performs the width change and drops null lanes.
- Guarantees that no output entry spans a packet boundary.

Parameters:
- S_KEEP_WIDTH, 3, input lanes per beat.
- T_DATA_WIDTH, 1, bits per lane.
- M_KEEP_WIDTH, 2, output lanes per entry.
- DEPTH, 8, lane FIFO depth in lanes. Power of two; DEPTH >= S_KEEP_WIDTH + M_KEEP_WIDTH.
- BUF_OUT_ENTRY_SZ, (2+T_DATA_WIDTH)*M_KEEP_WIDTH, entry width.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- s_valid_i  input  1  input beat valid.
- s_ready_o  output  1  beat accepted when s_valid_i & s_ready_o.
- s_last_i  input  1  final beat of packet.
- s_keep_i  input  S_KEEP_WIDTH  lane-valid mask, bit i for lane i.
- s_data_i  input  T_DATA_WIDTH x S_KEEP_WIDTH (unpacked array)  lane data.
- underflow  output  1  entry not yet presentable.
- master_entry_ready  input  1  consumer takes the current entry.
- master_entry  output  BUF_OUT_ENTRY_SZ  packed lanes.
  - Lane j: bit j*(2+W) = keep, bit j*(2+W)+1 = last, bits [j*(2+W)+2 +: W] = data (W = T_DATA_WIDTH).

Behaviour:
- Reset (async, immediate): rd/wr pointers = 0, count = 0, last_cnt = 0; master_entry = 0; underflow = 1; s_ready_o = 1 once rst deasserts.
- Reset mid-packet discards all FIFO contents and any partial packet.
- s_ready_o is combinational: (DEPTH - count) >= S_KEEP_WIDTH, using count before any same-cycle pop.
- Push, on accept:
  - Kept lanes (s_keep_i[i]=1) are written in ascending lane order to consecutive FIFO slots. Holes are squeezed out.
  - The last flag is set only on the highest kept lane, and only when s_last_i=1.
  - Each written lane stores keep=1.
- Zero-keep beat: accepted and discarded with no write. If s_last_i=1 it is a protocol violation; flag it with an assertion and drop it.
- last_cnt counts lanes with last=1 in the FIFO.
- Entry assembly (combinational from FIFO head), lane j = slot rd+j (mod DEPTH):
  - Valid only if j < count and no last flag exists at any lane below j in this entry.
  - Invalid lanes drive keep=0, last=0, data=0.
- underflow = (count < M_KEEP_WIDTH) && (last_cnt == 0). A packet tail flushes a partial entry.
- Pop: when master_entry_ready && !underflow, advance rd by n = number of valid lanes in the entry, where n = min(count, M_KEEP_WIDTH, first_last_index+1).
  - master_entry_ready while underflow=1 is ignored.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped; last_cnt updates likewise.
- Pointer wrap: modulo DEPTH with no bubble cycle.
- Latency: a beat written at edge N is visible on master_entry after edge N.
- Full: s_ready_o=0 holds the beat; no data is lost.
- Empty: master_entry = 0 and underflow = 1.
- count width: $clog2(DEPTH+1); pointer width: $clog2(DEPTH).

Decomposition:
- resizer_pkg holds:
  - localparam LANE_W = 2+T_DATA_WIDTH.
  - lane field offsets: KEEP_BIT=0, LAST_BIT=1, DATA_LSB=2.
  - lane_t struct {data, last, keep}.
  - count/pointer width helper functions.
- One sub-module, lane_fifo:
  - Multi-write/multi-read circular buffer: up to S lanes in and M lanes out per cycle, with count.
- slave_packer keeps the compaction, last tagging, entry masking and underflow logic.

Test Plan (defaults S=3, M=2, W=1, DEPTH=8):
- Single beat keep=111, data=1,0,1, last=1 -> entry1 keep=11 data=1,0 last=00 underflow=0. After pop, entry2 keep=01 last=01 data lane0=1. After pop: underflow=1, master_entry=0.
- Beat keep=101 data=1,x,0 last=0 -> lanes compacted: count=2, entry keep=11 data=1,0, underflow=0.
- Two packets: P1 keep=001 last=1, then P2 keep=111 last=1 ->
  - First entry keep=01 last=01, P1 only; pop n=1.
  - Next entry keep=11 last=00, then keep=01 last=01.
- Hold master_entry_ready=0 with continuous s_valid_i=1 keep=111 last=0 -> accepts 2 beats (count=6), then s_ready_o=0. One pop of 2 lanes gives count=4; s_ready_o rises the same cycle; the next beat takes count to 7.
- Steady push (keep=111) and pop in the same cycle over 20 beats -> data order preserved across pointer wrap; count never exceeds 8.
- Assert rst with count=5 mid-packet -> same-cycle: underflow=1, master_entry=0; s_ready_o=1 after release. A new packet drains intact.
